// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready ALU with accumulator forwarding, flags and consumed-result counter
module alu_pipe #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       sel,
   input  logic             use_acc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             neg,
   output logic             ovf,
   output logic [CNT_W-1:0] op_count
);
   localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   logic             s1_valid, s1_use_acc, s1_load, s2_load, c, v;
   logic [2:0]       s1_sel;
   logic [WIDTH-1:0] s1_a, s1_b, acc, opa, res;
   logic [SW-1:0]    sh;
   assign s2_load  = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || !out_valid || out_ready;
   assign s1_load  = in_valid && in_ready;
   // compute result and flags from stage-1 contents; accumulator substitutes operand a when requested
   always_comb begin
      opa = s1_use_acc ? acc : s1_a;
      sh  = s1_b[SW-1:0];
      res = '0;
      c   = 1'b0;
      v   = 1'b0;
      case (s1_sel)
         3'd0: begin
            {c, res} = {1'b0, opa} + {1'b0, s1_b};
            v = (opa[WIDTH-1] == s1_b[WIDTH-1]) && (res[WIDTH-1] != opa[WIDTH-1]);
         end
         3'd1: begin
            {c, res} = {1'b0, opa} - {1'b0, s1_b};
            v = (opa[WIDTH-1] != s1_b[WIDTH-1]) && (res[WIDTH-1] != opa[WIDTH-1]);
         end
         3'd2: res = opa & s1_b;
         3'd3: res = opa | s1_b;
         3'd4: res = opa ^ s1_b;
         3'd5: res = ~opa;
         3'd6: {c, res} = {1'b0, opa} << sh;
         default: {res, c} = {opa, 1'b0} >> sh;
      endcase
   end
   // stage 1: capture the offered operation whenever it is accepted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_a       <= '0;
         s1_b       <= '0;
         s1_sel     <= '0;
         s1_use_acc <= 1'b0;
      end else begin
         s1_valid <= s1_load ? 1'b1 : s2_load ? 1'b0 : s1_valid;
         if (s1_load) begin
            s1_a       <= a;
            s1_b       <= b;
            s1_sel     <= sel;
            s1_use_acc <= use_acc;
         end
      end
   end
   // stage 2: register result/flags and update accumulator on transfer; hold while stalled
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         result    <= '0;
         carry     <= 1'b0;
         zero      <= 1'b0;
         neg       <= 1'b0;
         ovf       <= 1'b0;
         acc       <= '0;
      end else if (s2_load) begin
         out_valid <= 1'b1;
         result    <= res;
         carry     <= c;
         zero      <= (res == '0);
         neg       <= res[WIDTH-1];
         ovf       <= v;
         acc       <= res;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
   // count consumed results, wrapping naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) op_count <= '0;
      else if (out_valid && out_ready) op_count <= op_count + 1'b1;
   end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed self-checking bench for alu_pipe (WIDTH=4)
module tb_alu_pipe;
   logic       clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b1, use_acc = 1'b0;
   logic       in_ready, out_valid, carry, zero, neg, ovf;
   logic [3:0] a = '0, b = '0, result;
   logic [2:0] sel = '0;
   logic [7:0] op_count, exp_cnt;
   int         tests = 0, fails = 0;
   wire  [7:0] obs = {result, carry, zero, neg, ovf};

   // {sel, a, b, expected {result, carry, zero, neg, ovf}}
   logic [18:0] tbl [14] = '{
      {3'd0, 4'b0101, 4'b0011, 8'b1000_0011},
      {3'd0, 4'b1111, 4'b0001, 8'b0000_1100},
      {3'd1, 4'b0011, 4'b0101, 8'b1110_1010},
      {3'd1, 4'b0101, 4'b0101, 8'b0000_0100},
      {3'd1, 4'b1000, 4'b0001, 8'b0111_0001},
      {3'd2, 4'b1100, 4'b1010, 8'b1000_0010},
      {3'd3, 4'b1100, 4'b1010, 8'b1110_0010},
      {3'd4, 4'b1100, 4'b1010, 8'b0110_0000},
      {3'd5, 4'b1100, 4'b1111, 8'b0011_0000},
      {3'd6, 4'b0011, 4'b0010, 8'b1100_0010},
      {3'd7, 4'b1101, 4'b0001, 8'b0110_1000},
      {3'd6, 4'b0011, 4'b0000, 8'b0011_0000},
      {3'd6, 4'b1011, 4'b0100, 8'b1011_0010},
      {3'd7, 4'b1100, 4'b0011, 8'b0001_1000}
   };

   alu_pipe #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sel(sel), .use_acc(use_acc),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .carry(carry), .zero(zero), .neg(neg), .ovf(ovf), .op_count(op_count)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] s, input logic [3:0] x, input logic [3:0] y, input logic u);
      sel = s;
      a = x;
      b = y;
      use_acc = u;
      in_valid = 1'b1;
   endtask

   task automatic test_reset;
      #1 rst = 1'b1;
      #1;
      tests++;
      if ({out_valid, in_ready, obs, op_count} !== {1'b0, 1'b1, 8'h00, 8'h00}) begin
         fails++;
         $display("FAIL reset_async: got v=%b r=%b o=%b c=%0d expected v=0 r=1 o=00000000 c=0", out_valid, in_ready, obs, op_count);
      end
      tick;
      tick;
      rst = 1'b0;
      exp_cnt = 8'd0;
      tests++;
      if ({out_valid, in_ready, obs, op_count} !== {1'b0, 1'b1, 8'h00, 8'h00}) begin
         fails++;
         $display("FAIL reset_clocked: got v=%b r=%b o=%b c=%0d expected v=0 r=1 o=00000000 c=0", out_valid, in_ready, obs, op_count);
      end
   endtask

   task automatic test_latency;
      drive(3'd0, 4'b0101, 4'b0011, 1'b0);
      tick;
      in_valid = 1'b0;
      tests++;
      if (out_valid !== 1'b0) begin
         fails++;
         $display("FAIL latency_early: got out_valid=%b expected 0", out_valid);
      end
      tick;
      tests++;
      if ({out_valid, obs} !== {1'b1, 8'b1000_0011}) begin
         fails++;
         $display("FAIL latency_add: got v=%b o=%b expected v=1 o=10000011", out_valid, obs);
      end
      tick;
      exp_cnt++;
   endtask

   task automatic test_ops;
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i][18:16], tbl[i][15:12], tbl[i][11:8], 1'b0);
         tick;
         in_valid = 1'b0;
         tick;
         tests++;
         if ({out_valid, obs} !== {1'b1, tbl[i][7:0]}) begin
            fails++;
            $display("FAIL op_%0d: got v=%b o=%b expected v=1 o=%b", i, out_valid, obs, tbl[i][7:0]);
         end
         tick;
         exp_cnt++;
      end
      tests++;
      if (op_count !== exp_cnt) begin
         fails++;
         $display("FAIL ops_count: got %0d expected %0d", op_count, exp_cnt);
      end
   endtask

   task automatic test_back_to_back;
      drive(3'd0, 4'b0101, 4'b0011, 1'b0);
      tick;
      drive(3'd0, 4'b0000, 4'b1000, 1'b1);
      tick;
      in_valid = 1'b0;
      tests++;
      if ({out_valid, obs} !== {1'b1, 8'b1000_0011}) begin
         fails++;
         $display("FAIL b2b_first: got v=%b o=%b expected v=1 o=10000011", out_valid, obs);
      end
      tick;
      tests++;
      if ({out_valid, obs} !== {1'b1, 8'b0000_1101}) begin
         fails++;
         $display("FAIL b2b_acc: got v=%b o=%b expected v=1 o=00001101", out_valid, obs);
      end
      tick;
      exp_cnt += 8'd2;
      tests++;
      if ({out_valid, op_count} !== {1'b0, exp_cnt}) begin
         fails++;
         $display("FAIL b2b_count: got v=%b c=%0d expected v=0 c=%0d", out_valid, op_count, exp_cnt);
      end
   endtask

   task automatic test_stall;
      out_ready = 1'b0;
      drive(3'd0, 4'b0001, 4'b0001, 1'b0);
      tick;
      drive(3'd4, 4'b1111, 4'b0101, 1'b0);
      tick;
      drive(3'd3, 4'b0100, 4'b0001, 1'b0);
      tests++;
      if ({out_valid, in_ready, obs} !== {1'b1, 1'b0, 8'b0010_0000}) begin
         fails++;
         $display("FAIL stall_full: got v=%b r=%b o=%b expected v=1 r=0 o=00100000", out_valid, in_ready, obs);
      end
      tick;
      tick;
      tests++;
      if ({out_valid, in_ready, obs} !== {1'b1, 1'b0, 8'b0010_0000}) begin
         fails++;
         $display("FAIL stall_hold: got v=%b r=%b o=%b expected v=1 r=0 o=00100000", out_valid, in_ready, obs);
      end
      out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      tests++;
      if ({out_valid, obs} !== {1'b1, 8'b1010_0010}) begin
         fails++;
         $display("FAIL stall_second: got v=%b o=%b expected v=1 o=10100010", out_valid, obs);
      end
      tick;
      tests++;
      if ({out_valid, obs} !== {1'b1, 8'b0101_0000}) begin
         fails++;
         $display("FAIL stall_third: got v=%b o=%b expected v=1 o=01010000", out_valid, obs);
      end
      tick;
      exp_cnt += 8'd3;
      tests++;
      if ({out_valid, op_count} !== {1'b0, exp_cnt}) begin
         fails++;
         $display("FAIL stall_count: got v=%b c=%0d expected v=0 c=%0d", out_valid, op_count, exp_cnt);
      end
   endtask

   task automatic test_reset_mid;
      out_ready = 1'b0;
      drive(3'd0, 4'b0011, 4'b0011, 1'b0);
      tick;
      drive(3'd3, 4'b1010, 4'b0101, 1'b0);
      tick;
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      exp_cnt = 8'd0;
      tests++;
      if ({out_valid, in_ready, obs, op_count} !== {1'b0, 1'b1, 8'h00, 8'h00}) begin
         fails++;
         $display("FAIL rst_mid: got v=%b r=%b o=%b c=%0d expected v=0 r=1 o=00000000 c=0", out_valid, in_ready, obs, op_count);
      end
      out_ready = 1'b1;
      tick;
      rst = 1'b0;
      tick;
      tick;
      tick;
      tests++;
      if ({out_valid, op_count} !== {1'b0, 8'h00}) begin
         fails++;
         $display("FAIL rst_flush: got v=%b c=%0d expected v=0 c=0", out_valid, op_count);
      end
   endtask

   task automatic test_wrap;
      drive(3'd0, 4'b0001, 4'b0001, 1'b0);
      for (int i = 0; i < 260; i++) begin
         tick;
         exp_cnt++;
      end
      in_valid = 1'b0;
      tick;
      tick;
      tick;
      tests++;
      if ({out_valid, op_count} !== {1'b0, exp_cnt}) begin
         fails++;
         $display("FAIL count_wrap: got v=%b c=%0d expected v=0 c=%0d", out_valid, op_count, exp_cnt);
      end
   endtask

   initial begin
      test_reset;
      test_latency;
      test_ops;
      test_back_to_back;
      test_stall;
      test_reset_mid;
      test_wrap;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 4: operand/result width in bits; legal values 4..32.
REQ-002 Parameter CNT_W, default 8: width of the completed-operation counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  operation offered.
REQ-006 in_ready  output  1  block accepts the offered operation this cycle.
REQ-007 a, b  input  WIDTH each  operands.
REQ-008 sel  input  3  opcode.
REQ-009 use_acc  input  1  replace a with the accumulator value.
REQ-010 out_valid  output  1  result/flags valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 result  output  WIDTH  operation result.
REQ-013 carry, zero, neg, ovf  output  1 each  flags.
REQ-014 op_count  output  CNT_W  count of results consumed (out_valid && out_ready).

Function
REQ-015 Opcodes: 000 ADD a+b; 001 SUB a-b; 010 AND; 011 OR; 100 XOR; 101 NOT a (b ignored); 110 SHL a by b[log2(WIDTH)-1:0]; 111 SHR (logical) by the same amount.
REQ-016 carry: ADD = carry-out; SUB = borrow (1 iff a<b unsigned); SHL/SHR = last bit shifted out, 0 for shift amount 0; logic ops = 0.
REQ-017 zero = (result==0); neg = result[WIDTH-1]; ovf = two's-complement overflow for ADD/SUB, 0 for all other ops.
REQ-018 Two-stage pipeline: stage 1 registers a, b, sel, use_acc on accept (in_valid && in_ready); stage 2 registers result and flags computed from stage-1 contents.
REQ-019 Latency: an operation accepted at edge N has out_valid high after edge N+1, i.e. two edges from offer to valid; throughput one operation per cycle with out_ready held high.
REQ-020 Stage 2 loads when stage 1 is valid and (!out_valid || out_ready); stage 1 loads when in_valid and (stage 1 empty or stage 1 moves to stage 2 this cycle).
REQ-021 in_ready = !s1_valid || !out_valid || out_ready (combinational, no dependency on in_valid).
REQ-022 result and flags are held stable while out_valid && !out_ready; no operation is dropped, duplicated or reordered.
REQ-023 Internal accumulator (WIDTH bits) loads the computed result at every stage-1 to stage-2 transfer; an operation with use_acc=1 uses the accumulator value at its own compute time, so back-to-back dependent operations see the immediately preceding result with no bubble.
REQ-024 op_count increments by 1 per consumed result and wraps from all-ones to 0.
REQ-025 Simultaneous accept and output consumption in one cycle are both honoured.

Reset
REQ-026 On rst high, immediately and without a clock: s1_valid=0, out_valid=0, result=0, carry=zero=neg=ovf=0, accumulator=0, op_count=0; in_ready=1.
REQ-027 Reset asserted mid-operation discards all in-flight operations; no output handshake follows from them after release.
REQ-028 First accept is possible at the first rising edge with rst low.

Verification (WIDTH=4, out_ready=1 unless stated)
REQ-029 ADD a=0101 b=0011 -> result 1000, carry 0, zero 0, neg 1, ovf 1, out_valid two edges after offer.
REQ-030 SUB a=0011 b=0101 -> result 1110, carry 1, neg 1, ovf 0; SUB a=0101 b=0101 -> 0000, zero 1, carry 0.
REQ-031 SHL a=0011 b=0010 -> 1100, carry 0; SHR a=1101 b=0001 -> 0110, carry 1; SHL b=0000 -> a unchanged, carry 0.
REQ-032 Back-to-back: ADD 0101+0011, then ADD use_acc=1 b=1000 -> second result 0000, carry 1, zero 1, ovf 1.
REQ-033 out_ready=0 for 4 cycles while offering 3 ops -> two held internally, in_ready low, third waits; on release the outputs are in order, no loss, op_count=3.
REQ-034 rst pulse while 2 ops are in flight -> all outputs and op_count 0 within the same cycle, no out_valid afterwards until new input.
